// File: rtl/pipe4_pkg.sv
// Shared types and helpers for the 1-of-4 elastic buffer.
package pipe4_pkg;

  // Width of the dropped-flit counter.
  localparam int ERR_W = 8;

  // Handshake events decoded for one clock cycle.
  typedef struct packed {
    logic push;  // valid flit written into the FIFO
    logic pop;   // head flit taken downstream
    logic drop;  // invalid flit handshaken but discarded
  } hs_t;

  // True when exactly one of the four rails of a sub-channel is high.
  function automatic logic onehot4_ok(input logic d0, input logic d1,
                                      input logic d2, input logic d3);
    logic any_pair;
    any_pair = (d0 & d1) | (d0 & d2) | (d0 & d3) |
               (d1 & d2) | (d1 & d3) | (d2 & d3);
    return (d0 | d1 | d2 | d3) & ~any_pair;
  endfunction

  // 1-of-4 to binary index. Only meaningful for a valid codeword.
  function automatic logic [1:0] enc4(input logic d0, input logic d1,
                                      input logic d2, input logic d3);
    logic unused_d0;
    unused_d0 = d0;  // rail 0 is implied by the other three being low
    return {d3 | d2, d3 | d1};
  endfunction

  // Binary index to 1-of-4 rails, bit v set for value v.
  function automatic logic [3:0] dec4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/pipe4_codec.sv
// Combinational 1-of-4 codec: checks and packs incoming rails, and
// re-expands stored binary into rails gated by an enable.
module pipe4_codec
  import pipe4_pkg::*;
#(
  parameter int SCN = 16
) (
  input  logic [SCN-1:0]   i_d0,
  input  logic [SCN-1:0]   i_d1,
  input  logic [SCN-1:0]   i_d2,
  input  logic [SCN-1:0]   i_d3,
  output logic             o_ok,
  output logic [2*SCN-1:0] o_packed,
  input  logic [2*SCN-1:0] i_packed,
  input  logic             i_en,
  output logic [SCN-1:0]   o_d0,
  output logic [SCN-1:0]   o_d1,
  output logic [SCN-1:0]   o_d2,
  output logic [SCN-1:0]   o_d3
);

  logic [3:0] w_rails;

  // Input side: AND of per-sub-channel validity, and the packed indices.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the loop can leave it unassigned and infer a latch.
    o_ok     = 1'b1;
    o_packed = '0;
    for (int k = 0; k < SCN; k++) begin
      o_ok = o_ok & onehot4_ok(i_d0[k], i_d1[k], i_d2[k], i_d3[k]);
      o_packed[2*k +: 2] = enc4(i_d0[k], i_d1[k], i_d2[k], i_d3[k]);
    end
  end

  // Output side: decode each stored index and gate with the enable so the
  // rails sit at the all-zero spacer whenever nothing is presented.
  always_comb begin
    o_d0    = '0;
    o_d1    = '0;
    o_d2    = '0;
    o_d3    = '0;
    w_rails = '0;
    for (int k = 0; k < SCN; k++) begin
      w_rails = dec4(i_packed[2*k +: 2]);
      o_d0[k] = i_en & w_rails[0];
      o_d1[k] = i_en & w_rails[1];
      o_d2[k] = i_en & w_rails[2];
      o_d3[k] = i_en & w_rails[3];
    end
  end

endmodule

// File: rtl/pipe4_sync.sv
// Clocked elastic buffer for 1-of-4 encoded flits. Valid flits are packed
// to 2 bits per sub-channel into a circular FIFO; invalid ones are
// handshaken, dropped and counted.
module pipe4_sync
  import pipe4_pkg::*;
#(
  parameter int DW     = 32,
  parameter int SCN    = DW / 2,
  parameter int DEPTH  = 4,
  parameter int EOF_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SCN-1:0]             in_d0,
  input  logic [SCN-1:0]             in_d1,
  input  logic [SCN-1:0]             in_d2,
  input  logic [SCN-1:0]             in_d3,
  input  logic                       in_eof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SCN-1:0]             out_d0,
  output logic [SCN-1:0]             out_d1,
  output logic [SCN-1:0]             out_d2,
  output logic [SCN-1:0]             out_d3,
  output logic                       out_eof,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       code_err,
  output logic [ERR_W-1:0]           err_cnt
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PKW = 2 * SCN;
  localparam int SW  = PKW + EOF_EN;

  logic [SW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_code_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic             w_in_ok;
  logic [PKW-1:0]   w_in_packed;
  logic [SW-1:0]    w_wr_word;
  logic [SW-1:0]    w_rd_word;
  logic             w_rd_eof;
  logic             w_accept;
  hs_t              w_hs;

  // Handshake flags are pure functions of the count register, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid & in_ready;

  // Classify this cycle's handshakes.
  always_comb begin
    w_hs      = '0;
    w_hs.push = w_accept & w_in_ok;
    w_hs.drop = w_accept & ~w_in_ok;
    w_hs.pop  = out_valid & out_ready;
  end

  pipe4_codec #(.SCN(SCN)) u_codec (
    .i_d0     (in_d0),
    .i_d1     (in_d1),
    .i_d2     (in_d2),
    .i_d3     (in_d3),
    .o_ok     (w_in_ok),
    .o_packed (w_in_packed),
    .i_packed (w_rd_word[PKW-1:0]),
    .i_en     (out_valid),
    .o_d0     (out_d0),
    .o_d1     (out_d1),
    .o_d2     (out_d2),
    .o_d3     (out_d3)
  );

  // The eof bit occupies the top of each entry only when it is carried.
  if (EOF_EN != 0) begin : g_eof
    assign w_wr_word = {in_eof, w_in_packed};
    assign w_rd_eof  = w_rd_word[SW-1];
  end else begin : g_no_eof
    assign w_wr_word = w_in_packed;
    assign w_rd_eof  = 1'b0;
  end

  assign w_rd_word = r_mem[r_rd_ptr];
  assign out_eof   = out_valid & w_rd_eof;

  // Storage write on an accepted valid flit.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are never visible
    // because the outputs are gated by out_valid, which reset clears.
    if (w_hs.push) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  // Pointers and occupancy count, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_hs.push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_hs.pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_hs.push, w_hs.pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drop reporting: one-cycle pulse plus a saturating counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_code_err <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_code_err <= w_hs.drop;
      if (w_hs.drop && (r_err_cnt != {ERR_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign count    = r_count;
  assign code_err = r_code_err;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_pipe4_sync.sv
// Self-checking bench for pipe4_sync: scoreboard queue filled by the
// driver, drained by an independent output monitor, plus directed checks.
module tb_pipe4_sync;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] d3;
    logic        eof;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_d0, in_d1, in_d2, in_d3;
  logic        in_eof;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_d0, out_d1, out_d2, out_d3;
  logic        out_eof;
  logic [2:0]  count;
  logic        code_err;
  logic [7:0]  err_cnt;

  int    n_chk = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;
  flit_t sb[$];

  pipe4_sync #(.DW(32), .DEPTH(4), .EOF_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d0     (in_d0),
    .in_d1     (in_d1),
    .in_d2     (in_d2),
    .in_d3     (in_d3),
    .in_eof    (in_eof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_d0    (out_d0),
    .out_d1    (out_d1),
    .out_d2    (out_d2),
    .out_d3    (out_d3),
    .out_eof   (out_eof),
    .count     (count),
    .code_err  (code_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: 2-bit value per sub-channel to 1-of-4 rails.
  function automatic flit_t mk(input logic [31:0] val, input logic eof);
    flit_t f;
    f.d0 = '0; f.d1 = '0; f.d2 = '0; f.d3 = '0;
    for (int k = 0; k < 16; k++) begin
      case (val[2*k +: 2])
        2'd0: f.d0[k] = 1'b1;
        2'd1: f.d1[k] = 1'b1;
        2'd2: f.d2[k] = 1'b1;
        default: f.d3[k] = 1'b1;
      endcase
    end
    f.eof = eof;
    return f;
  endfunction

  // Move to the drive point just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one flit; wait (bounded) for in_ready; record it if valid.
  task automatic push(input flit_t f, input logic good);
    int w;
    w = 0;
    in_d0 = f.d0; in_d1 = f.d1; in_d2 = f.d2; in_d3 = f.d3;
    in_eof = f.eof;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check("push_ready_timeout", {63'd0, in_ready}, 64'd1);
    else if (good) sb.push_back(f);
    tick();
    in_valid = 1'b0;
  endtask

  // Output monitor: compares popped flits with the scoreboard and checks
  // the spacer whenever nothing is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", {63'd0, out_valid}, 64'd0);
        end else begin
          flit_t e;
          e = sb.pop_front();
          check("out_rails", {out_d3, out_d2, out_d1, out_d0},
                {e.d3, e.d2, e.d1, e.d0});
          check("out_eof", {63'd0, out_eof}, {63'd0, e.eof});
        end
      end else if (out_valid === 1'b0) begin
        check("idle_rails", {out_d3, out_d2, out_d1, out_d0}, 64'd0);
        check("idle_eof", {63'd0, out_eof}, 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    flit_t f;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_eof = 1'b0;
    in_d0 = '0; in_d1 = '0; in_d2 = '0; in_d3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Reset state.
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_code_err", {63'd0, code_err}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);

    // First flit: all sub-channels value 0, eof=1.
    push(mk(32'h0000_0000, 1'b1), 1'b1);
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_d0", {48'd0, out_d0}, 64'h0000_FFFF);
    check("first_d123", {16'd0, out_d3, out_d2, out_d1}, 64'd0);
    check("first_eof", {63'd0, out_eof}, 64'd1);
    check("first_count", {61'd0, count}, 64'd1);

    // Fill to DEPTH with distinct flits.
    push(mk(32'h5555_5555, 1'b0), 1'b1);
    push(mk(32'hAAAA_AAAA, 1'b1), 1'b1);
    push(mk(32'h1B1B_E4E4, 1'b0), 1'b1);
    check("full_count", {61'd0, count}, 64'd4);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);

    // A fifth flit must not be taken while full.
    f = mk(32'hFFFF_FFFF, 1'b1);
    in_d0 = f.d0; in_d1 = f.d1; in_d2 = f.d2; in_d3 = f.d3; in_eof = f.eof;
    in_valid = 1'b1;
    repeat (2) tick();
    check("full_hold_count", {61'd0, count}, 64'd4);
    in_valid = 1'b0;

    // Drain in order.
    out_ready = 1'b1;
    repeat (4) tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_count", {61'd0, count}, 64'd0);
    check("drain_in_ready", {63'd0, in_ready}, 64'd1);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Stream 100 flits at full rate; occupancy stays at 1.
    for (int i = 0; i < 100; i++) begin
      push(mk($urandom, 1'($urandom_range(0, 1))), 1'b1);
      check("stream_count", {61'd0, count}, 64'd1);
    end
    tick();
    check("stream_drained", {61'd0, count}, 64'd0);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Double-hot sub-channel 3 is dropped; next valid flit passes intact.
    out_ready = 1'b0;
    f = mk(32'h0000_0040, 1'b0);
    f.d2[3] = 1'b1;
    push(f, 1'b0);
    check("bad_code_err", {63'd0, code_err}, 64'd1);
    check("bad_err_cnt", {56'd0, err_cnt}, 64'd1);
    check("bad_count", {61'd0, count}, 64'd0);
    push(mk(32'h9C9C_3636, 1'b1), 1'b1);
    check("after_bad_code_err", {63'd0, code_err}, 64'd0);
    check("after_bad_count", {61'd0, count}, 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();
    check("after_bad_sb_empty", 64'(sb.size()), 64'd0);

    // 300 back-to-back bad flits: spacer and double-hot alternately.
    for (int i = 0; i < 300; i++) begin
      f = mk(32'h0000_0000, 1'b0);
      if (i % 2 == 0) f.d0 = '0;
      else f.d3[i % 16] = 1'b1;
      push(f, 1'b0);
      check("burst_code_err", {63'd0, code_err}, 64'd1);
    end
    check("burst_err_sat", {56'd0, err_cnt}, 64'd255);
    check("burst_count", {61'd0, count}, 64'd0);
    tick();
    check("burst_end_code_err", {63'd0, code_err}, 64'd0);
    check("burst_end_err_cnt", {56'd0, err_cnt}, 64'd255);

    // Reset with three entries held.
    out_ready = 1'b0;
    push(mk(32'h0123_4567, 1'b1), 1'b1);
    push(mk(32'h89AB_CDEF, 1'b0), 1'b1);
    push(mk(32'hFEDC_BA98, 1'b1), 1'b1);
    check("pre_rst_count", {61'd0, count}, 64'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("mid_rst_count", {61'd0, count}, 64'd0);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_rails", {out_d3, out_d2, out_d1, out_d0}, 64'd0);
    check("mid_rst_eof", {63'd0, out_eof}, 64'd0);
    check("mid_rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Buffer works normally after reset.
    push(mk(32'h3333_CCCC, 1'b0), 1'b1);
    out_ready = 1'b1;
    repeat (2) tick();
    check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe4_sync.md
# pipe4_sync

Clocked elastic buffer for 1-of-4 encoded SDM NoC flits. It replaces a chain of QDI pipeline stages wherever a router port crosses into the synchronous test and IO domain. Each incoming flit is checked for codeword validity and packed to binary, 2 bits per sub-channel, in a DEPTH-entry circular FIFO. On output it is re-expanded to 1-of-4 rails, and the rails read all-zero (the spacer) whenever no flit is presented.

## Interface
- DW, 32: payload bits per flit; must be even.
- SCN, DW/2: number of 1-of-4 sub-channels.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- EOF_EN, 1: 1 carries the eof bit through the buffer; 0 forces out_eof to 0 and ignores in_eof.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream flit present.
- in_ready  out  1  buffer can accept a flit.
- in_d0..in_d3  in  SCN each  1-of-4 rails; sub-channel k value v is in_dv[k]=1.
- in_eof  in  1  end-of-frame flag.
- out_valid  out  1  flit presented downstream.
- out_ready  in  1  downstream accepts.
- out_d0..out_d3  out  SCN each  1-of-4 rails; all zero when out_valid=0.
- out_eof  out  1  eof of the presented flit; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  entries held.
- code_err  out  1  one-cycle pulse when an invalid flit is dropped.
- err_cnt  out  8  number of dropped flits; saturates at 255.

## Operation
- Push: in_valid & in_ready. Pop: out_valid & out_ready.
- Codeword check at push:
  - Each sub-channel k must have exactly one of in_d0[k]..in_d3[k] high.
  - If any sub-channel has zero or more than one rail high, the flit is dropped. Nothing is written and count is unchanged.
  - A dropped flit asserts code_err on the next cycle and increments err_cnt.
  - A dropped flit is still handshaken (in_ready honoured), so upstream is never stalled by a bad flit.
- Encoding: stored value for sub-channel k is the index of its hot rail (0..3). On output, out_dv[k] = out_valid & (stored==v).
- Storage is DEPTH × (2·SCN + EOF_EN) bits, with write and read pointers of $clog2(DEPTH) bits that wrap naturally.
- in_ready = (count < DEPTH). This is a registered function of count, with no combinational path from out_ready.
- out_valid = (count != 0). Data is read from the read pointer, so the outputs are a mux of registers plus the decode.
- Simultaneous push and pop: count holds and both pointers advance. When the buffer is full, in_ready=0, so a push cannot coincide with the pop.
- Reset (rst_n=0 at a clk edge):
  - Pointers, count and err_cnt are cleared to 0; code_err=0.
  - Result: in_ready=1, out_valid=0, all out rails 0, out_eof=0.
  - Reset mid-operation discards all contents; storage RAM is not cleared.

## Timing
- Latency: a flit pushed at edge N is presented (out_valid=1) after edge N, i.e. available for pop at edge N+1. There is no same-cycle bypass.
- Throughput: 1 flit per cycle sustained when out_ready=1 and 0 < count < DEPTH.
- After a pop from full, in_ready rises in the same cycle that count drops, i.e. the cycle after the pop edge.
- code_err is high for exactly one cycle per dropped flit. Back-to-back bad flits give back-to-back pulses.
- err_cnt updates on the same edge that raises code_err.
- All outputs are registered or decoded from registers. The only comb inputs to flops are the handshake signals.

## Structure
- Shared package pipe4_pkg:
  - Function onehot4_ok(d0,d1,d2,d3) for a 1-bit sub-channel.
  - Functions enc4 (1-of-4 to 2-bit) and dec4 (2-bit to 1-of-4).
  - Localparam ERR_W=8.
- Sub-module pipe4_codec: SCN-wide, purely combinational. It gives per-flit valid (AND over sub-channels) and packed binary on the input side, and unpacks on the output side.
- The FIFO control (pointers, count, handshake, error counter) lives in pipe4_sync itself.

## Test plan
- Reset, then push flit with in_d0=16'hFFFF (all zeros value), eof=1, out_ready=0.
  - Next cycle: out_valid=1, out_d0=16'hFFFF, out_d1..3=0, out_eof=1, count=1.
- Fill with DEPTH=4 distinct flits while out_ready=0.
  - count=4, in_ready=0, a 5th in_valid is not accepted.
  - Then out_ready=1 for 4 cycles: the flits emerge in order, then out_valid=0 and all rails read 0.
- Stream 100 random valid flits with out_ready=1 continuously.
  - One flit out per cycle after 1 cycle latency, data identical to input, count stays 1.
- Inject a flit with sub-channel 3 having in_d1[3]=in_d2[3]=1.
  - Flit dropped, code_err=1 for one cycle, err_cnt=1, count unchanged, the following valid flit passes intact.
- Inject 300 consecutive bad flits: err_cnt saturates at 255 and code_err pulses every cycle.
- Assert rst_n=0 for one edge with count=3: count=0, out_valid=0, rails 0, err_cnt=0, in_ready=1.
